tag_array_nway: RTL and testbench
=================================

Name: tag_array_nway

Overview:
- Parametrised N-way set-associative tag store for the L1 cache.
- Successor to the fixed 2-way, 32-set, 23-bit tag wrapper.
- Adds per-entry valid bits, a hardware invalidation sweep after reset and on flush, and registered hit detection (hit vector, encoded hit way, multi-hit error).
- Sits between the cache controller FSM and its data array; storage is an internal synchronous-read array.

Parameters:
- NUM_WAYS, 4, number of ways; legal range 1..8.
- SET_BITS, 5, index width; SETS = 2**SET_BITS.
- TAG_BITS, 23, stored tag width.
- WAY_BITS, derived as max(1, clog2(NUM_WAYS)), width of the encoded way; not overridable.

Ports:
- CK  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- flush_req  in  1  one-cycle pulse; invalidate all entries.
- ready  out  1  high when lookups and writes are accepted.
- A  in  SET_BITS  set index for lookup and write.
- lookup_en  in  1  lookup request for set A, tag tag_in.
- tag_in  in  TAG_BITS  tag to compare.
- WEB  in  NUM_WAYS  per-way write enable, active-low; writes DI and sets valid.
- inv_en  in  1  invalidate ways selected by inv_mask in set A.
- inv_mask  in  NUM_WAYS  per-way invalidate select.
- DI  in  TAG_BITS  write tag.
- rd_valid  out  1  lookup result valid this cycle.
- hit_vec  out  NUM_WAYS  per-way (valid && tag match).
- hit  out  1  OR of hit_vec.
- hit_way  out  WAY_BITS  lowest-index set bit of hit_vec; 0 on miss.
- multi_hit  out  1  more than one hit_vec bit set (error).
- DO  out  NUM_WAYS*TAG_BITS  stored tags of set A; way k at [k*TAG_BITS +: TAG_BITS].
- VO  out  NUM_WAYS  stored valid bits of set A.

Behaviour:
- Reset, sampled synchronously on rst=1 at the CK edge:
  - state=S_INIT, sweep counter=0, ready=0.
  - rd_valid, hit_vec, hit, hit_way, multi_hit, VO all 0; DO all 0.
  - Tag contents are not cleared.
- FSM, two states:
  - S_INIT: each cycle clears valid[counter][all ways], then counter += 1. After clearing set SETS-1, moves to S_IDLE. ready rises exactly SETS cycles after rst deasserts (32 for the defaults).
  - S_IDLE: ready=1. flush_req=1 resets counter to 0 and returns to S_INIT (ready=0 from the next cycle).
- In S_INIT, lookup_en, WEB, inv_en and flush_req are ignored and rd_valid stays 0.
- rst asserted at any time, including mid-sweep, restarts the sweep at set 0.
- Lookup latency is 1 cycle. lookup_en in cycle t (with ready=1) gives rd_valid=1 in cycle t+1 with hit_vec/hit/hit_way/multi_hit/DO/VO for set A and tag_in sampled at t.
- Outputs hold their last values when rd_valid=0; rd_valid is a single-cycle pulse per request.
- Write: each WEB[k]=0 writes tag[A][k]=DI and valid[A][k]=1. Multiple ways may be written in the same cycle.
- Invalidate: inv_en=1 clears valid[A][k] for each inv_mask[k]=1; tags are unchanged.
- Same way in the same cycle with WEB[k]=0 and inv_en&&inv_mask[k]: the write wins (valid=1).
- Lookup and write/invalidate to the same set in the same cycle: read-before-write. The lookup result reflects the old contents; the new contents are visible to a lookup one cycle later.
- Tag compare is full TAG_BITS equality, gated by valid.
- multi_hit is for diagnostics only; hit_way still reports the lowest index.
- NUM_WAYS=1: hit_way is a constant 0 of width 1.

Decomposition:
- Package cache_pkg holds:
  - state enum {S_INIT, S_IDLE};
  - the WAY_BITS derivation function;
  - a first-one priority-encoder function, shared with the data-array way-select logic.
- One sub-module, tag_way_bank: a single way of SETS x (TAG_BITS+1) storage with sync read, write and valid-clear ports, instantiated NUM_WAYS times by a generate loop. Hit/encode logic stays in the top.

Test Plan:
- Reset sweep: pulse rst, then hold idle → ready=0 for exactly 32 cycles, then 1. A lookup on every set returns VO=4'b0000, hit=0.
- Write then hit: write WEB=4'b1011, A=5, DI=23'h1ABCDE. Next cycle lookup A=5, tag_in=23'h1ABCDE → one cycle later rd_valid=1, hit_vec=4'b0100, hit_way=2, VO=4'b0100, DO way2=23'h1ABCDE.
- Read-before-write: in one cycle write way0 at A=7 with DI=23'h000123 and look up A=7, tag 23'h000123 → hit=0. Repeat the lookup next cycle → hit=1, hit_way=0.
- Multi-hit and priority: write DI=23'h55 into ways 1 and 3 at A=9, then look up → hit_vec=4'b1010, hit_way=1, multi_hit=1.
- Invalidate and collision: inv_en with inv_mask=4'b1000 at A=9 → lookup gives hit_vec=4'b0010, multi_hit=0. Then inv_mask=4'b0010 together with WEB=4'b1101 in the same cycle → way1 stays valid.
- Flush and reset mid-sweep:
  - flush_req in S_IDLE → ready low for 32 cycles; all VO=0 afterwards.
  - rst at sweep cycle 10 → ready rises 32 cycles after rst deasserts, not 22.
  - lookups issued during the sweep → rd_valid stays 0.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared L1 cache definitions: the way-count helpers and the way-select priority
// encoder that the tag and data arrays both use.
package cache_pkg;

  localparam int MAX_WAYS     = 8;
  localparam int MAX_WAY_BITS = 3;

  typedef logic [MAX_WAYS-1:0] way_vec_t;

  typedef enum logic {
    S_INIT,
    S_IDLE
  } state_e;

  // A one-way cache still carries a 1-bit way field so the port never collapses.
  function automatic int way_bits(input int num_ways);
    return (num_ways > 1) ? $clog2(num_ways) : 1;
  endfunction

  function automatic logic [MAX_WAY_BITS-1:0] first_one(input way_vec_t vec);
    first_one = '0;
    for (int i = MAX_WAYS - 1; i >= 0; i--) begin
      if (vec[i]) first_one = MAX_WAY_BITS'(i);
    end
  endfunction

endpackage

// File: rtl/tag_way_bank.sv
// One way of the tag store: SETS x (tag + valid) with a registered read port,
// a tag/valid write port and a valid-clear port.
module tag_way_bank #(
  parameter int SET_BITS = 5,
  parameter int TAG_BITS = 23
) (
  input  logic                CK,
  input  logic                rst,
  input  logic                rd_en,
  input  logic [SET_BITS-1:0] rd_addr,
  input  logic                wr_en,
  input  logic [SET_BITS-1:0] wr_addr,
  input  logic [TAG_BITS-1:0] wr_tag,
  input  logic                clr_en,
  input  logic [SET_BITS-1:0] clr_addr,
  output logic [TAG_BITS-1:0] rd_tag,
  output logic                rd_vld
);

  localparam int SETS = 2 ** SET_BITS;

  logic [TAG_BITS-1:0] tag_mem [SETS];
  logic [SETS-1:0]     valid_q, valid_d;
  logic [TAG_BITS-1:0] rd_tag_q, rd_tag_d;
  logic                rd_vld_q, rd_vld_d;

  // A write applied after the clear lets a same-cycle write win over an invalidate.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    valid_d = valid_q;
    if (clr_en) valid_d[clr_addr] = 1'b0;
    if (wr_en)  valid_d[wr_addr]  = 1'b1;
  end

  always_comb begin
    rd_tag_d = rd_en ? tag_mem[rd_addr] : rd_tag_q;
    rd_vld_d = rd_en ? valid_q[rd_addr] : rd_vld_q;
  end

  // NOTE: storage is not reset; the valid bits are cleared by the sweep instead.
  always_ff @(posedge CK) begin
    valid_q <= valid_d;
    if (wr_en) tag_mem[wr_addr] <= wr_tag;
  end

  always_ff @(posedge CK) begin
    // NOTE: non-blocking assignments make the read see pre-write contents.
    if (rst) begin
      rd_tag_q <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      rd_tag_q <= rd_tag_d;
      rd_vld_q <= rd_vld_d;
    end
  end

  assign rd_tag = rd_tag_q;
  assign rd_vld = rd_vld_q;

endmodule

// File: rtl/tag_array_nway.sv
// N-way set-associative L1 tag store with valid bits, an invalidation sweep
// after reset/flush, and one-cycle hit detection.
module tag_array_nway
  import cache_pkg::*;
#(
  parameter  int NUM_WAYS = 4,
  parameter  int SET_BITS = 5,
  parameter  int TAG_BITS = 23,
  localparam int WAY_BITS = way_bits(NUM_WAYS)
) (
  input  logic                         CK,
  input  logic                         rst,
  input  logic                         flush_req,
  output logic                         ready,
  input  logic [SET_BITS-1:0]          A,
  input  logic                         lookup_en,
  input  logic [TAG_BITS-1:0]          tag_in,
  input  logic [NUM_WAYS-1:0]          WEB,
  input  logic                         inv_en,
  input  logic [NUM_WAYS-1:0]          inv_mask,
  input  logic [TAG_BITS-1:0]          DI,
  output logic                         rd_valid,
  output logic [NUM_WAYS-1:0]          hit_vec,
  output logic                         hit,
  output logic [WAY_BITS-1:0]          hit_way,
  output logic                         multi_hit,
  output logic [NUM_WAYS*TAG_BITS-1:0] DO,
  output logic [NUM_WAYS-1:0]          VO
);

  localparam int SETS = 2 ** SET_BITS;

  state_e              state_q;
  logic [SET_BITS-1:0] cnt_q;
  logic                ready_q;

  always_ff @(posedge CK) begin
    if (rst) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        S_INIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == SET_BITS'(SETS - 1)) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
          end
        end
        S_IDLE: begin
          if (flush_req) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
            ready_q <= 1'b0;
          end
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

  logic                rd_en, sweeping;
  logic                rd_valid_q, rd_valid_d;
  logic [TAG_BITS-1:0] tag_cmp_q, tag_cmp_d;

  assign sweeping = (state_q == S_INIT);
  assign rd_en    = lookup_en && ready_q;

  // The compare tag is captured with the read so results hold between lookups.
  always_comb begin
    rd_valid_d = rd_en;
    tag_cmp_d  = rd_en ? tag_in : tag_cmp_q;
  end

  always_ff @(posedge CK) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      tag_cmp_q  <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      tag_cmp_q  <= tag_cmp_d;
    end
  end

  logic [TAG_BITS-1:0] rd_tag [NUM_WAYS];
  logic [NUM_WAYS-1:0] rd_vld;

  for (genvar k = 0; k < NUM_WAYS; k++) begin : g_way
    tag_way_bank #(
      .SET_BITS(SET_BITS),
      .TAG_BITS(TAG_BITS)
    ) u_bank (
      .CK      (CK),
      .rst     (rst),
      .rd_en   (rd_en),
      .rd_addr (A),
      .wr_en   (ready_q && !WEB[k]),
      .wr_addr (A),
      .wr_tag  (DI),
      .clr_en  (sweeping || (ready_q && inv_en && inv_mask[k])),
      .clr_addr(sweeping ? cnt_q : A),
      .rd_tag  (rd_tag[k]),
      .rd_vld  (rd_vld[k])
    );
    assign DO[k*TAG_BITS +: TAG_BITS] = rd_tag[k];
  end

  logic [NUM_WAYS-1:0]     hit_vec_c;
  way_vec_t                hit_pad;
  logic [MAX_WAY_BITS-1:0] hit_enc;

  always_comb begin
    hit_vec_c = '0;
    for (int k = 0; k < NUM_WAYS; k++) begin
      hit_vec_c[k] = rd_vld[k] && (rd_tag[k] == tag_cmp_q);
    end
    hit_pad                 = '0;
    hit_pad[NUM_WAYS-1:0]   = hit_vec_c;
    hit_enc                 = first_one(hit_pad);
  end

  assign ready     = ready_q;
  assign rd_valid  = rd_valid_q;
  assign hit_vec   = hit_vec_c;
  assign hit       = |hit_vec_c;
  assign hit_way   = hit_enc[WAY_BITS-1:0];
  assign multi_hit = |(hit_vec_c & (hit_vec_c - 1'b1));
  assign VO        = rd_vld;

endmodule

// File: tb/tb_tag_array_nway.sv
// Directed bench for tag_array_nway: vector table for lookups/writes/invalidates
// plus hand-written reset, flush and mid-sweep reset sequences.
module tb_tag_array_nway;

  localparam int NW = 4;
  localparam int SB = 5;
  localparam int TB = 23;
  localparam int WB = 2;

  logic          CK = 1'b0;
  logic          rst, flush_req, lookup_en, inv_en;
  logic [SB-1:0] A;
  logic [TB-1:0] tag_in, DI;
  logic [NW-1:0] WEB, inv_mask;
  logic          ready, rd_valid, hit, multi_hit;
  logic [NW-1:0] hit_vec, VO;
  logic [WB-1:0] hit_way;
  logic [NW*TB-1:0] DO;

  int n_vec = 0;
  int n_bad = 0;

  tag_array_nway #(.NUM_WAYS(NW), .SET_BITS(SB), .TAG_BITS(TB)) dut (
    .CK(CK), .rst(rst), .flush_req(flush_req), .ready(ready), .A(A),
    .lookup_en(lookup_en), .tag_in(tag_in), .WEB(WEB), .inv_en(inv_en),
    .inv_mask(inv_mask), .DI(DI), .rd_valid(rd_valid), .hit_vec(hit_vec),
    .hit(hit), .hit_way(hit_way), .multi_hit(multi_hit), .DO(DO), .VO(VO)
  );

  always #5 CK = ~CK;

  typedef struct {
    logic [SB-1:0] a;
    logic          look;
    logic [TB-1:0] tag;
    logic [NW-1:0] web;
    logic          inv;
    logic [NW-1:0] imask;
    logic [TB-1:0] di;
    logic          e_rv;
    logic          full;
    logic [NW-1:0] e_hv;
    logic          e_hit;
    logic [WB-1:0] e_way;
    logic          e_mh;
    logic [NW-1:0] e_vo;
    int            do_way;
    logic [TB-1:0] e_do;
  } vec_t;

  function automatic vec_t mk(
    input logic [SB-1:0] a, input logic look, input logic [TB-1:0] tag,
    input logic [NW-1:0] web, input logic inv, input logic [NW-1:0] imask,
    input logic [TB-1:0] di, input logic e_rv, input logic full,
    input logic [NW-1:0] e_hv, input logic e_hit, input logic [WB-1:0] e_way,
    input logic e_mh, input logic [NW-1:0] e_vo, input int do_way,
    input logic [TB-1:0] e_do);
    vec_t v;
    v.a = a; v.look = look; v.tag = tag; v.web = web; v.inv = inv;
    v.imask = imask; v.di = di; v.e_rv = e_rv; v.full = full; v.e_hv = e_hv;
    v.e_hit = e_hit; v.e_way = e_way; v.e_mh = e_mh; v.e_vo = e_vo;
    v.do_way = do_way; v.e_do = e_do;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    flush_req = 1'b0; lookup_en = 1'b0; inv_en = 1'b0;
    WEB = '1; inv_mask = '0; tag_in = '0; DI = '0; A = '0;
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic apply(input vec_t v, input int idx);
    A = v.a; lookup_en = v.look; tag_in = v.tag; WEB = v.web;
    inv_en = v.inv; inv_mask = v.imask; DI = v.di;
    tick();
    idle_inputs();
    check($sformatf("v%0d rd_valid", idx), 64'(rd_valid), 64'(v.e_rv));
    if (v.e_rv || v.full) begin
      check($sformatf("v%0d hit_vec", idx),   64'(hit_vec),   64'(v.e_hv));
      check($sformatf("v%0d hit", idx),       64'(hit),       64'(v.e_hit));
      check($sformatf("v%0d hit_way", idx),   64'(hit_way),   64'(v.e_way));
      check($sformatf("v%0d multi_hit", idx), 64'(multi_hit), 64'(v.e_mh));
      check($sformatf("v%0d VO", idx),        64'(VO),        64'(v.e_vo));
    end
    if (v.do_way >= 0)
      check($sformatf("v%0d DO way%0d", idx, v.do_way),
            64'(DO[v.do_way*TB +: TB]), 64'(v.e_do));
  endtask

  // Counts edges until ready rises, issuing lookups that must all be dropped.
  task automatic sweep_count(input string name);
    int  n = 0;
    bit  saw_rv = 1'b0;
    lookup_en = 1'b1;
    WEB = 4'b0000;
    inv_en = 1'b1; inv_mask = '1;
    while (!ready && n < 100) begin
      A = 5'(n);
      tick();
      n++;
      if (rd_valid) saw_rv = 1'b1;
    end
    idle_inputs();
    check({name, " ready latency"}, 64'(n), 64'd32);
    check({name, " rd_valid during sweep"}, 64'(saw_rv), 64'd0);
  endtask

  task automatic lookup_all_empty(input string name);
    for (int s = 0; s < 32; s++) begin
      A = 5'(s); lookup_en = 1'b1; tag_in = '0;
      tick();
      idle_inputs();
      check($sformatf("%s set%0d {rd_valid,hit,VO}", name, s),
            64'({rd_valid, hit, VO}), 64'(6'b100000));
    end
  endtask

  vec_t vecs[17];

  initial begin
    //          a      lk    tag          web      inv   imask    di           rv    full  hv       hit   way    mh    vo       dw  do
    vecs[0]  = mk(5'd5,  1'b0, 23'h0,       4'b1011, 1'b0, 4'b0000, 23'h1ABCDE, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000, -1, 23'h0);
    vecs[1]  = mk(5'd5,  1'b1, 23'h1ABCDE,  4'b1111, 1'b0, 4'b0000, 23'h0,      1'b1, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b0, 4'b0100,  2, 23'h1ABCDE);
    vecs[2]  = mk(5'd7,  1'b1, 23'h000123,  4'b1110, 1'b0, 4'b0000, 23'h000123, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000, -1, 23'h0);
    vecs[3]  = mk(5'd7,  1'b1, 23'h000123,  4'b1111, 1'b0, 4'b0000, 23'h0,      1'b1, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0, 4'b0001,  0, 23'h000123);
    vecs[4]  = mk(5'd9,  1'b0, 23'h0,       4'b0101, 1'b0, 4'b0000, 23'h55,     1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000, -1, 23'h0);
    vecs[5]  = mk(5'd9,  1'b1, 23'h55,      4'b1111, 1'b0, 4'b0000, 23'h0,      1'b1, 1'b0, 4'b1010, 1'b1, 2'd1, 1'b1, 4'b1010,  3, 23'h55);
    vecs[6]  = mk(5'd9,  1'b0, 23'h0,       4'b1111, 1'b1, 4'b1000, 23'h0,      1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000, -1, 23'h0);
    vecs[7]  = mk(5'd9,  1'b1, 23'h55,      4'b1111, 1'b0, 4'b0000, 23'h0,      1'b1, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b0, 4'b0010,  3, 23'h55);
    vecs[8]  = mk(5'd9,  1'b0, 23'h0,       4'b1101, 1'b1, 4'b0010, 23'h55,     1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000, -1, 23'h0);
    vecs[9]  = mk(5'd9,  1'b1, 23'h55,      4'b1111, 1'b0, 4'b0000, 23'h0,      1'b1, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b0, 4'b0010,  1, 23'h55);
    vecs[10] = mk(5'd9,  1'b1, 23'h56,      4'b1111, 1'b0, 4'b0000, 23'h0,      1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0010,  1, 23'h55);
    vecs[11] = mk(5'd3,  1'b0, 23'h0,       4'b1111, 1'b0, 4'b0000, 23'h0,      1'b0, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0010,  1, 23'h55);
    vecs[12] = mk(5'd5,  1'b1, 23'h1ABCDE,  4'b1111, 1'b1, 4'b0100, 23'h0,      1'b1, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b0, 4'b0100,  2, 23'h1ABCDE);
    vecs[13] = mk(5'd5,  1'b1, 23'h1ABCDE,  4'b1111, 1'b0, 4'b0000, 23'h0,      1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000,  2, 23'h1ABCDE);
    vecs[14] = mk(5'd31, 1'b0, 23'h0,       4'b0111, 1'b0, 4'b0000, 23'h7FFFFF, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000, -1, 23'h0);
    vecs[15] = mk(5'd31, 1'b1, 23'h7FFFFF,  4'b1111, 1'b0, 4'b0000, 23'h0,      1'b1, 1'b0, 4'b1000, 1'b1, 2'd3, 1'b0, 4'b1000,  3, 23'h7FFFFF);
    vecs[16] = mk(5'd0,  1'b1, 23'h0,       4'b1111, 1'b0, 4'b0000, 23'h0,      1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000, -1, 23'h0);

    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    check("reset ready",     64'(ready),     64'd0);
    check("reset rd_valid",  64'(rd_valid),  64'd0);
    check("reset hit_vec",   64'(hit_vec),   64'd0);
    check("reset hit_way",   64'(hit_way),   64'd0);
    check("reset multi_hit", 64'(multi_hit), 64'd0);
    check("reset VO",        64'(VO),        64'd0);
    check("reset DO",        64'(DO),        64'd0);
    rst = 1'b0;
    sweep_count("post-reset");
    lookup_all_empty("post-reset");

    foreach (vecs[i]) apply(vecs[i], i);

    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    check("flush ready drop", 64'(ready), 64'd0);
    sweep_count("flush");
    lookup_all_empty("post-flush");

    // Reset ten cycles into a flush sweep must restart the full sweep.
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("mid-sweep ready", 64'(ready), 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid-sweep reset ready", 64'(ready), 64'd0);
    sweep_count("mid-sweep reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
